// File: rtl/posit_defines_es3.sv
`default_nettype none
// ============================================================================
// Module   : posit_defines_es3 (package)
// Brief    : Shared widths and the serialized value layout for ES=3 posits.
// Revision : 1.0 - initial release
// ============================================================================
package posit_defines_es3;

    localparam int NBITS                      = 32;
    localparam int ES                         = 3;
    localparam int FBITS                      = NBITS - ES - 3;
    localparam int SCALE_BITS                 = 9;
    localparam int POSIT_SERIALIZED_WIDTH_ES3 = 1 + SCALE_BITS + FBITS + 2;
    localparam int SCALE_MAX_ES3              = (NBITS - 2) << ES;

    typedef struct packed {
        logic                  sgn;
        logic [SCALE_BITS-1:0] scale;
        logic [FBITS-1:0]      fraction;
        logic                  inf;
        logic                  zero;
    } value;

endpackage
`default_nettype wire

// File: rtl/posit_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : posit_pipe_ctrl
// Brief    : Valid/load chain for a bubble-collapsing register pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module posit_pipe_ctrl #(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_ready,
    output logic [STAGES-1:0] o_load,
    output logic [STAGES-1:0] o_valid
);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_src;

    assign w_src   = {r_valid[STAGES-2:0], i_valid};
    assign o_valid = r_valid;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            // A stage may load if it or any stage downstream has a hole,
            // or the consumer is draining the last stage.
            assign o_load[k] = i_ready | ~(&r_valid[STAGES-1:k]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[k] <= 1'b0;
                end else if (o_load[k]) begin
                    r_valid[k] <= w_src[k];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/posit_mult_pipe_es3.sv
`default_nettype none
// ============================================================================
// Module   : posit_mult_pipe_es3
// Brief    : Three-stage pipelined multiplier for serialized ES=3 posits.
// Revision : 1.0 - initial release
// ============================================================================
module posit_mult_pipe_es3
    import posit_defines_es3::*;
#(
    parameter int SCALE_MAX = SCALE_MAX_ES3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] in_a,
    input  logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] in_b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] out_product,
    output logic                                  out_truncated
);

    localparam int                 c_STAGES    = 3;
    localparam logic signed [10:0] c_SCALE_MAX = 11'(SCALE_MAX);
    localparam logic signed [10:0] c_SCALE_MIN = -c_SCALE_MAX;

    logic [c_STAGES-1:0] w_load;
    logic [c_STAGES-1:0] w_valid;

    posit_pipe_ctrl #(
        .STAGES (c_STAGES)
    ) u_ctrl (
        .clk     (clk),
        .rst     (reset),
        .i_valid (in_valid),
        .i_ready (out_ready),
        .o_load  (w_load),
        .o_valid (w_valid)
    );

    assign in_ready  = w_load[0];
    assign out_valid = w_valid[2];

    // ---------------- stage 1: operand capture ----------------
    value r_s1_a;
    value r_s1_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_a <= '0;
            r_s1_b <= '0;
        end else if (w_load[0] && in_valid) begin
            r_s1_a <= value'(in_a);
            r_s1_b <= value'(in_b);
        end
    end

    // ---------------- stage 2: sign, scale sum, mantissa product ----------------
    logic               w_inf;
    logic               w_zero;
    logic               w_special;
    logic signed [10:0] w_scale_sum;
    logic [53:0]        w_prod;

    assign w_inf       = r_s1_a.inf | r_s1_b.inf;
    assign w_zero      = ~w_inf & (r_s1_a.zero | r_s1_b.zero);
    assign w_special   = w_inf | w_zero;
    assign w_scale_sum = {{2{r_s1_a.scale[8]}}, r_s1_a.scale}
                       + {{2{r_s1_b.scale[8]}}, r_s1_b.scale};
    assign w_prod      = 54'({1'b1, r_s1_a.fraction}) * 54'({1'b1, r_s1_b.fraction});

    logic               r_s2_sgn;
    logic signed [10:0] r_s2_scale;
    logic [53:0]        r_s2_prod;
    logic               r_s2_inf;
    logic               r_s2_zero;

    // Specials carry an all-zero product so stage 3 emits a clean zero payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_sgn   <= 1'b0;
            r_s2_scale <= '0;
            r_s2_prod  <= '0;
            r_s2_inf   <= 1'b0;
            r_s2_zero  <= 1'b0;
        end else if (w_load[1] && w_valid[0]) begin
            r_s2_sgn   <= w_special ? 1'b0 : (r_s1_a.sgn ^ r_s1_b.sgn);
            r_s2_scale <= w_special ? '0 : w_scale_sum;
            r_s2_prod  <= w_special ? '0 : w_prod;
            r_s2_inf   <= w_inf;
            r_s2_zero  <= w_zero;
        end
    end

    // ---------------- stage 3: normalise and clamp ----------------
    logic signed [10:0] w_scale_adj;
    logic [8:0]         w_scale_out;
    logic [FBITS-1:0]   w_frac;
    logic               w_trunc;

    always_comb begin
        w_scale_adj = r_s2_scale;
        w_frac      = r_s2_prod[51:26];
        w_trunc     = |r_s2_prod[25:0];
        if (r_s2_prod[53]) begin
            w_scale_adj = r_s2_scale + 11'sd1;
            w_frac      = r_s2_prod[52:27];
            w_trunc     = |r_s2_prod[26:0];
        end
        w_scale_out = w_scale_adj[8:0];
        if (w_scale_adj > c_SCALE_MAX) begin
            w_scale_out = c_SCALE_MAX[8:0];
            w_frac      = '0;
            w_trunc     = 1'b0;
        end else if (w_scale_adj < c_SCALE_MIN) begin
            w_scale_out = c_SCALE_MIN[8:0];
            w_frac      = '0;
            w_trunc     = 1'b0;
        end
    end

    logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] r_s3_word;
    logic                                  r_s3_trunc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_word  <= '0;
            r_s3_trunc <= 1'b0;
        end else if (w_load[2] && w_valid[1]) begin
            r_s3_word  <= {r_s2_sgn, w_scale_out, w_frac, r_s2_inf, r_s2_zero};
            r_s3_trunc <= w_trunc;
        end
    end

    assign out_product   = r_s3_word;
    assign out_truncated = r_s3_trunc;

endmodule
`default_nettype wire
